// File: rtl/mem_store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_buffer_pkg
// Description : Shared CPU definitions for the MEM-stage store buffer:
//               default buffer depth and the buffered-store record layout.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_store_buffer_pkg;

    // Default number of buffered stores
    localparam int C_SB_DEPTH = 4;

    // One buffered store: byte address, word data, PC of the store
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pc;
    } sb_entry_t;

endpackage : mem_store_buffer_pkg
`default_nettype wire

// File: rtl/mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_buffer
// Description : Circular store buffer between the MEM stage and the data
//               memory. Drains stores in order when the write port is free
//               and forwards the youngest matching store to loads.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_store_buffer
    import mem_store_buffer_pkg::*;
#(
    parameter int DEPTH = C_SB_DEPTH,
    parameter int AW    = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_wd,
    input  logic [31:0]              st_pc,
    output logic                     st_ready,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hit,
    output logic [31:0]              ld_data,
    input  logic                     drain_en,
    output logic                     dm_we,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_wd,
    output logic [31:0]              dm_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t          r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;

    logic               w_push;
    logic               w_pop;
    logic [PW-1:0]      w_fidx   [DEPTH];
    logic [DEPTH-1:0]   w_fmatch;
    logic               w_unused_ld;

    // Address bits outside the compared word index play no part in matching
    assign w_unused_ld = ^{ld_addr[31:AW+2], ld_addr[1:0]};

    assign count    = r_count;
    assign empty    = (r_count == '0);
    assign st_ready = (r_count != CW'(DEPTH));
    assign w_push   = st_valid & st_ready;
    assign dm_we    = drain_en & ~empty;
    assign w_pop    = dm_we;

    // Head entry goes straight to the memory port; zeroed while empty
    assign dm_addr = empty ? 32'd0 : r_mem[r_head].addr;
    assign dm_wd   = empty ? 32'd0 : r_mem[r_head].wd;
    assign dm_pc   = empty ? 32'd0 : r_mem[r_head].pc;

    // Comparator per age slot: slot 0 is the oldest (head), slot DEPTH-1 the youngest
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_fwd
            assign w_fidx[i]   = r_head + PW'(i);
            assign w_fmatch[i] = r_valid[w_fidx[i]] &&
                                 (r_mem[w_fidx[i]].addr[AW+1:2] == ld_addr[AW+1:2]);
        end
    endgenerate

    // Youngest match wins: later (younger) slots override earlier ones
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_fmatch[i]) begin
                ld_hit  = 1'b1;
                ld_data = r_mem[w_fidx[i]].wd;
            end
        end
    end

    // Entry storage needs no reset; valid bits gate every use of it
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{addr: st_addr, wd: st_wd, pc: st_pc};
        end
    end

    // Pointer, occupancy and valid-bit bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : mem_store_buffer
`default_nettype wire
